// File: rtl/cardinal_pkg.sv
// Shared definitions between the router local port and the NIC:
// packet geometry, packet type and the injection-side state encoding.
package cardinal_pkg;

    localparam int PKT_W  = 64;
    localparam int VC_BIT = 0;

    typedef logic [PKT_W-1:0] pkt_t;

    // Injection arbiter: free to pick, or holding an offered packet.
    typedef enum logic {
        INJ_IDLE = 1'b0,
        INJ_HOLD = 1'b1
    } inj_state_e;

endpackage

// File: rtl/router_local_port_if.sv
// Signal bundle between the router local port, its NIC and the crossbar.
// master = the router local port, slave = the NIC/crossbar side.
interface router_local_port_if #(
    parameter int PKT_W = cardinal_pkg::PKT_W
);
    logic             polarity;
    logic             nic_so;
    logic             nic_ro;
    logic [PKT_W-1:0] nic_do;
    logic             nic_si;
    logic             nic_ri;
    logic [PKT_W-1:0] nic_di;
    logic             inj_valid;
    logic             inj_ready;
    logic [PKT_W-1:0] inj_data;
    logic             ej_valid;
    logic             ej_ready;
    logic [PKT_W-1:0] ej_data;
    logic             proto_err;
    logic [15:0]      cnt_in;
    logic [15:0]      cnt_out;

    modport master (
        output polarity, nic_ro, nic_si, nic_di, inj_valid, inj_data,
               ej_ready, proto_err, cnt_in, cnt_out,
        input  nic_so, nic_do, nic_ri, inj_ready, ej_valid, ej_data
    );

    modport slave (
        input  polarity, nic_ro, nic_si, nic_di, inj_valid, inj_data,
               ej_ready, proto_err, cnt_in, cnt_out,
        output nic_so, nic_do, nic_ri, inj_ready, ej_valid, ej_data
    );
endinterface

// File: rtl/vc_slot_buf.sv
// Two single-packet slots, one per virtual channel, with an indexed write,
// an indexed clear and per-slot full flags. Callers never fill and drain
// the same slot in one cycle, so no arbitration is provided for that case.
module vc_slot_buf #(
    parameter int PKT_W = cardinal_pkg::PKT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic                  wr_idx_i,
    input  logic [PKT_W-1:0]      wr_data_i,
    input  logic                  clr_en_i,
    input  logic                  clr_idx_i,
    output logic [1:0]            full_o,
    output logic [1:0][PKT_W-1:0] data_o
);
    logic [1:0]            full_q;
    logic [1:0][PKT_W-1:0] data_q;

    // Slot storage: write sets full and loads data, clear only drops full.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en_i && (wr_idx_i == 1'(i))) begin
                    data_q[i] <= wr_data_i;
                    full_q[i] <= 1'b1;
                end else if (clr_en_i && (clr_idx_i == 1'(i))) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
endmodule

// File: rtl/router_local_port.sv
// Router local port: bridges the NIC link (two VCs, polarity-scheduled)
// to the crossbar injection/ejection handshakes.
// Optional packet counters: define ROUTER_LOCAL_PORT_STATS_EN.
module router_local_port #(
    parameter int PKT_W  = cardinal_pkg::PKT_W,
    parameter int VC_BIT = cardinal_pkg::VC_BIT
) (
    input logic                 clk,
    input logic                 reset,
    router_local_port_if.master bus
);
    import cardinal_pkg::*;

    logic                  polarity_q, polarity_d;
    logic                  proto_err_q;
    logic [1:0]            in_full, out_full;
    logic [1:0][PKT_W-1:0] in_data, out_data;

    // NIC capture: target VC comes from the packet, full slot means drop.
    logic cap_vc, cap_ok, cap_drop;
    assign cap_vc   = bus.nic_do[VC_BIT];
    assign cap_ok   = bus.nic_so && !in_full[cap_vc];
    assign cap_drop = bus.nic_so &&  in_full[cap_vc];

    // Injection: selection is frozen while an offered packet is stalled.
    inj_state_e inj_st_q;
    logic       sel_q, rr_q, sel, inj_valid, inj_fire;
    assign sel       = (inj_st_q == INJ_HOLD) ? sel_q
                                              : (in_full[rr_q] ? rr_q : ~rr_q);
    assign inj_valid = !reset && (|in_full);
    assign inj_fire  = inj_valid && bus.inj_ready;

    // Ejection into egress slots and drain towards the NIC.
    logic ej_vc, ej_ready, ej_fire, nic_si;
    assign ej_vc    = bus.ej_data[VC_BIT];
    assign ej_ready = !reset && !out_full[ej_vc];
    assign ej_fire  = bus.ej_valid && ej_ready;
    assign nic_si   = !reset && out_full[polarity_q] && bus.nic_ri;

    assign polarity_d = ~polarity_q;

    // Link polarity alternates every cycle; protocol error is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            polarity_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            polarity_q <= polarity_d;
            if (cap_drop) proto_err_q <= 1'b1;
        end
    end

    // Round-robin injection arbiter with hold-while-stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            inj_st_q <= INJ_IDLE;
            sel_q    <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            case (inj_st_q)
                INJ_IDLE: begin
                    if (inj_valid) begin
                        if (bus.inj_ready) begin
                            rr_q <= ~sel;
                        end else begin
                            inj_st_q <= INJ_HOLD;
                            sel_q    <= sel;
                        end
                    end
                end
                INJ_HOLD: begin
                    if (bus.inj_ready) begin
                        inj_st_q <= INJ_IDLE;
                        rr_q     <= ~sel_q;
                    end
                end
                default: inj_st_q <= INJ_IDLE;
            endcase
        end
    end

    vc_slot_buf #(.PKT_W(PKT_W)) u_ingress (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (cap_ok),
        .wr_idx_i  (cap_vc),
        .wr_data_i (bus.nic_do),
        .clr_en_i  (inj_fire),
        .clr_idx_i (sel),
        .full_o    (in_full),
        .data_o    (in_data)
    );

    vc_slot_buf #(.PKT_W(PKT_W)) u_egress (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (ej_fire),
        .wr_idx_i  (ej_vc),
        .wr_data_i (bus.ej_data),
        .clr_en_i  (nic_si),
        .clr_idx_i (polarity_q),
        .full_o    (out_full),
        .data_o    (out_data)
    );

    assign bus.polarity  = polarity_q;
    assign bus.nic_ro    = !reset && !in_full[polarity_q];
    assign bus.inj_valid = inj_valid;
    assign bus.inj_data  = in_data[sel];
    assign bus.ej_ready  = ej_ready;
    assign bus.nic_si    = nic_si;
    assign bus.nic_di    = out_data[polarity_q];
    assign bus.proto_err = proto_err_q;

`ifdef ROUTER_LOCAL_PORT_STATS_EN
    logic [15:0] cnt_in_q, cnt_out_q;

    // Saturating transfer counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_in_q  <= '0;
            cnt_out_q <= '0;
        end else begin
            if (cap_ok && (cnt_in_q != 16'hFFFF))  cnt_in_q  <= cnt_in_q + 16'd1;
            if (nic_si && (cnt_out_q != 16'hFFFF)) cnt_out_q <= cnt_out_q + 16'd1;
        end
    end

    assign bus.cnt_in  = cnt_in_q;
    assign bus.cnt_out = cnt_out_q;
`else
    assign bus.cnt_in  = '0;
    assign bus.cnt_out = '0;
`endif
endmodule

// File: tb/tb_router_local_port.sv
// Bench for router_local_port: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_router_local_port;
    localparam int PKT_W  = 64;
    localparam int VC_BIT = 0;

    typedef logic [PKT_W-1:0] pq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_local_port_if #(.PKT_W(PKT_W)) bus();

    router_local_port #(.PKT_W(PKT_W), .VC_BIT(VC_BIT)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    int    n_run  = 0;
    int    n_fail = 0;
    string phase  = "reset";

    // Reference model: each VC slot is a queue of depth at most one.
    pq_t m_in [2];
    pq_t m_out[2];
    int  m_pol, m_rr, m_lock_vc, m_cin, m_cout;
    bit  m_lock, m_perr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h expected %h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int v = 0; v < 2; v++) begin
            m_in[v].delete();
            m_out[v].delete();
        end
        m_pol = 0; m_rr = 0; m_lock = 0; m_lock_vc = 0;
        m_perr = 0; m_cin = 0; m_cout = 0;
    endfunction

    function automatic int m_sel();
        if (m_lock) return m_lock_vc;
        return (m_in[m_rr].size() != 0) ? m_rr : 1 - m_rr;
    endfunction

    task automatic drive(input bit so, input logic [63:0] d, input bit ri,
                         input bit ir, input bit ev, input logic [63:0] ed);
        bus.nic_so = so; bus.nic_do = d; bus.nic_ri = ri;
        bus.inj_ready = ir; bus.ej_valid = ev; bus.ej_data = ed;
    endtask

    // One cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit iv, ejr, si, drop, so, ir, ejv;
        int s, ev, cv;
        logic [63:0] d, ed;
        logic [15:0] ec_in, ec_out;
        #1;
        s   = m_sel();
        iv  = !rst && (m_in[0].size() + m_in[1].size()) > 0;
        ev  = int'(bus.ej_data[VC_BIT]);
        ejr = !rst && m_out[ev].size() == 0;
        si  = !rst && m_out[m_pol].size() != 0 && bus.nic_ri;
`ifdef ROUTER_LOCAL_PORT_STATS_EN
        ec_in = 16'(m_cin); ec_out = 16'(m_cout);
`else
        ec_in = 16'd0; ec_out = 16'd0;
`endif
        chk("polarity",  64'(bus.polarity),  64'(m_pol));
        chk("nic_ro",    64'(bus.nic_ro),    64'(!rst && m_in[m_pol].size() == 0));
        chk("inj_valid", 64'(bus.inj_valid), 64'(iv));
        if (iv) chk("inj_data", bus.inj_data, m_in[s][0]);
        chk("ej_ready",  64'(bus.ej_ready),  64'(ejr));
        chk("nic_si",    64'(bus.nic_si),    64'(si));
        if (si) chk("nic_di", bus.nic_di, m_out[m_pol][0]);
        chk("proto_err", 64'(bus.proto_err), 64'(m_perr));
        chk("cnt_in",    64'(bus.cnt_in),    64'(ec_in));
        chk("cnt_out",   64'(bus.cnt_out),   64'(ec_out));
        so = bus.nic_so; d = bus.nic_do; ir = bus.inj_ready;
        ejv = bus.ej_valid; ed = bus.ej_data;
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            cv   = int'(d[VC_BIT]);
            drop = so && m_in[cv].size() != 0;
            if (iv && ir) begin
                void'(m_in[s].pop_front());
                m_rr = 1 - s; m_lock = 0;
            end else if (iv) begin
                m_lock = 1; m_lock_vc = s;
            end
            if (so) begin
                if (drop) m_perr = 1;
                else begin
                    m_in[cv].push_back(d);
                    if (m_cin < 65535) m_cin++;
                end
            end
            if (ejv && ejr) m_out[ev].push_back(ed);
            if (si) begin
                void'(m_out[m_pol].pop_front());
                if (m_cout < 65535) m_cout++;
            end
            m_pol = 1 - m_pol;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ri, input bit ir);
        for (int i = 0; i < n; i++) begin
            drive(0, 64'h0, ri, ir, 0, 64'h0);
            step();
        end
    endtask

    initial begin
        bit legal;
        logic [63:0] rd, re;
        rst = 1'b1;
        drive(0, 64'h0, 0, 0, 0, 64'h0);
        m_reset();
        @(negedge clk);
        idle(2, 0, 0);
        rst = 1'b0;

        phase = "idle";
        idle(6, 0, 0);

        phase = "nic_a0";
        drive(1, 64'h0000_0000_0000_00A0, 0, 1, 0, 64'h0);
        step();
        idle(3, 0, 1);

        phase = "both_vc";
        drive(1, 64'h0000_0000_0000_00C0, 0, 0, 0, 64'h0); step();
        drive(1, 64'h0000_0000_0000_00C1, 0, 0, 0, 64'h0); step();
        idle(5, 0, 0);
        idle(4, 0, 1);

        phase = "ej_51";
        drive(0, 64'h0, 1, 0, 1, 64'h0000_0000_0000_0051); step();
        idle(4, 1, 0);

        phase = "ri_low";
        drive(0, 64'h0, 0, 0, 1, 64'h0000_0000_0000_0050); step();
        drive(0, 64'h0, 0, 0, 0, 64'h0000_0000_0000_0050); step();
        drive(0, 64'h0, 0, 0, 0, 64'h0000_0000_0000_0051); step();
        idle(3, 0, 0);
        idle(3, 1, 0);

        phase = "proto";
        drive(1, 64'h0000_0000_1234_0000, 0, 0, 0, 64'h0); step();
        drive(1, 64'h0000_0000_5678_0000, 0, 0, 0, 64'h0); step();
        idle(2, 0, 0);
        idle(3, 0, 1);

        // Random traffic: first half follows the NIC protocol, second half
        // is unconstrained and includes occasional resets mid-transfer.
        phase = "rand";
        for (int c = 0; c < 4000; c++) begin
            legal = (c < 2000);
            rd = {$urandom, $urandom};
            re = {$urandom, $urandom};
            if (legal) rd[VC_BIT] = m_pol[0];
            rst = !legal && ($urandom_range(0, 63) == 0);
            drive(legal ? (m_in[m_pol].size() == 0 && $urandom_range(0, 1) == 1)
                        : ($urandom_range(0, 1) == 1),
                  rd, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, re);
            step();
        end

        phase = "final_reset";
        rst = 1'b1;
        idle(2, 1, 1);
        rst = 1'b0;
        idle(2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
